// File: rtl/wordcopy_dma.sv
// -----------------------------------------------------------------------------
// wordcopy_dma
//
// CPU-programmed word-copy DMA engine. The CPU programs DST, SRC and NWORDS
// through an Avalon-MM slave, then writes CTRL to start the copy. That CTRL
// write is stalled until the last word has been written. The engine reads
// NWORDS words from SRC and writes them to DST through an Avalon-MM master.
// Reads are pipelined: up to FIFO_DEPTH words can be requested or buffered at
// any time. Read data is held in an internal FIFO until it is written out.
//
// Handshake semantics (both Avalon-MM ports): a command is offered while its
// strobe (read/write) is high. It is accepted on the rising clock edge where
// waitrequest is low. While waitrequest is high the master holds address,
// data and strobe unchanged. Read data comes back in issue order, one word per
// readdatavalid pulse, at least one cycle after the read was accepted.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   slave_*               CPU register port (word index 0 CTRL, 1 DST, 2 SRC,
//                         3 NWORDS, 4 COUNT)
//   master_*              SDRAM port (byte addresses, DATA_W-wide data)
//   dbg_state_o           current FSM state (IDLE/RUN/DONE) for observation
//
// ADDR_W must not exceed 32, because SRC/DST are 32-bit CPU registers.
// -----------------------------------------------------------------------------
module wordcopy_dma #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              slave_waitrequest,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    output logic [31:0]       slave_readdata,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    input  logic              master_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,
    output logic [1:0]        dbg_state_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(BYTES - 1));
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]    OCC_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;

    // CPU-visible registers
    logic [31:0]        dst_q;
    logic [31:0]        src_q;
    logic [31:0]        nwords_q;
    logic [31:0]        count_q;
    logic               done_q;

    // Copy progress
    logic [ADDR_W-1:0]  rd_ptr_q;
    logic [ADDR_W-1:0]  wr_ptr_q;
    logic [31:0]        issued_q;
    logic [CNT_W-1:0]   outstanding_q;
    logic [CNT_W-1:0]   outstanding_d;

    // Read-data FIFO
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   fifo_wptr_q;
    logic [PTR_W-1:0]   fifo_rptr_q;
    logic [CNT_W-1:0]   fifo_cnt_q;
    logic [CNT_W-1:0]   fifo_cnt_d;

    // Registered master command
    logic [ADDR_W-1:0]  master_address_q;
    logic               master_read_q;
    logic               master_write_q;
    logic [DATA_W-1:0]  master_writedata_q;

    logic               run;
    logic               cmd_stall;
    logic               rd_ret;
    logic               wr_ret;
    logic               last_wr;
    logic               push;
    logic               do_write;
    logic               do_read;
    logic [CNT_W:0]     occ;
    logic [31:0]        reg_mux;

    assign run       = (state_q == S_RUN);
    assign cmd_stall = (master_read_q | master_write_q) & master_waitrequest;
    assign rd_ret    = master_read_q  & ~master_waitrequest;
    assign wr_ret    = master_write_q & ~master_waitrequest;
    assign last_wr   = run & wr_ret & (count_q + 32'd1 == nwords_q);

    // Data for a read that is still waiting to be accepted also needs a slot,
    // so the pending read strobe is counted along with accepted reads and
    // buffered words. Writes free their slot at issue, since they pop the FIFO.
    assign occ = (CNT_W + 1)'(outstanding_q) + (CNT_W + 1)'(fifo_cnt_q)
               + (CNT_W + 1)'(master_read_q);

    // Data arriving with no read in flight (e.g. left over from before a
    // reset) is dropped.
    assign push = run & master_readdatavalid & (outstanding_q != '0);

    // Writes take priority: draining the FIFO frees credit for more reads.
    assign do_write = run & ~cmd_stall & ~last_wr & (fifo_cnt_q != '0);
    assign do_read  = run & ~cmd_stall & ~last_wr & (fifo_cnt_q == '0)
                    & (issued_q < nwords_q) & (occ < OCC_LIMIT);

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !do_write) begin
            fifo_cnt_d = fifo_cnt_q + CNT_ONE;
        end else if (!push && do_write) begin
            fifo_cnt_d = fifo_cnt_q - CNT_ONE;
        end

        outstanding_d = outstanding_q;
        if (rd_ret && !push) begin
            outstanding_d = outstanding_q + CNT_ONE;
        end else if (!rd_ret && push) begin
            outstanding_d = outstanding_q - CNT_ONE;
        end
    end

    // FIFO storage has no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wptr_q] <= master_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q            <= S_IDLE;
            dst_q              <= '0;
            src_q              <= '0;
            nwords_q           <= '0;
            count_q            <= '0;
            done_q             <= 1'b0;
            rd_ptr_q           <= '0;
            wr_ptr_q           <= '0;
            issued_q           <= '0;
            outstanding_q      <= '0;
            fifo_wptr_q        <= '0;
            fifo_rptr_q        <= '0;
            fifo_cnt_q         <= '0;
            master_address_q   <= '0;
            master_read_q      <= 1'b0;
            master_write_q     <= 1'b0;
            master_writedata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (slave_write) begin
                        case (slave_address)
                            4'd0: begin
                                rd_ptr_q      <= src_q[ADDR_W-1:0] & ADDR_MASK;
                                wr_ptr_q      <= dst_q[ADDR_W-1:0] & ADDR_MASK;
                                count_q       <= '0;
                                issued_q      <= '0;
                                outstanding_q <= '0;
                                fifo_wptr_q   <= '0;
                                fifo_rptr_q   <= '0;
                                fifo_cnt_q    <= '0;
                                if (nwords_q == 32'd0) begin
                                    done_q  <= 1'b1;
                                    state_q <= S_DONE;
                                end else begin
                                    done_q  <= 1'b0;
                                    state_q <= S_RUN;
                                end
                            end
                            4'd1:    dst_q    <= slave_writedata;
                            4'd2:    src_q    <= slave_writedata;
                            4'd3:    nwords_q <= slave_writedata;
                            default: ;
                        endcase
                    end
                end

                S_RUN: begin
                    outstanding_q <= outstanding_d;
                    fifo_cnt_q    <= fifo_cnt_d;
                    if (push) begin
                        fifo_wptr_q <= fifo_wptr_q + PTR_ONE;
                    end
                    if (wr_ret) begin
                        count_q <= count_q + 32'd1;
                    end

                    // A stalled command keeps address, data and strobe as-is.
                    if (!cmd_stall) begin
                        master_read_q  <= do_read;
                        master_write_q <= do_write;
                        if (do_write) begin
                            master_address_q   <= wr_ptr_q;
                            master_writedata_q <= fifo_mem[fifo_rptr_q];
                            wr_ptr_q           <= wr_ptr_q + STRIDE;
                            fifo_rptr_q        <= fifo_rptr_q + PTR_ONE;
                        end else if (do_read) begin
                            master_address_q <= rd_ptr_q;
                            rd_ptr_q         <= rd_ptr_q + STRIDE;
                            issued_q         <= issued_q + 32'd1;
                        end
                    end

                    if (last_wr) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    // The stalled CTRL write completes during this cycle.
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign slave_waitrequest = run
                             | ((state_q == S_IDLE) & slave_write & (slave_address == 4'd0));

    always_comb begin
        reg_mux = 32'h0;
        case (slave_address)
            4'd0:    reg_mux = {31'b0, done_q};
            4'd1:    reg_mux = dst_q;
            4'd2:    reg_mux = src_q;
            4'd3:    reg_mux = nwords_q;
            4'd4:    reg_mux = count_q;
            default: reg_mux = 32'h0;
        endcase
        slave_readdata = slave_read ? reg_mux : 32'h0;
    end

    assign master_address   = master_address_q;
    assign master_read      = master_read_q;
    assign master_write     = master_write_q;
    assign master_writedata = master_writedata_q;
    assign dbg_state_o      = state_q;

endmodule
